// File: rtl/ir_beacon_tx_pkg.sv
// Shared decision codes, default beacon periods and FSM state type for the IR beacon transmitter.
// The receiver-side detector uses the same code values and period defaults.
package ir_beacon_tx_pkg;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_RB   = 3'd1;
    localparam logic [2:0] CODE_RG   = 3'd2;
    localparam logic [2:0] CODE_BG   = 3'd3;
    localparam logic [2:0] CODE_STOP = 3'd4;

    // Clocks per period at 100 MHz: 200 Hz, 1 kHz, 5 kHz, ~7.1 kHz
    localparam int DEF_PER_RB   = 500000;
    localparam int DEF_PER_RG   = 100000;
    localparam int DEF_PER_BG   = 20000;
    localparam int DEF_PER_STOP = 14000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic code_legal(input logic [2:0] code);
        return (code != CODE_NONE) && (code <= CODE_STOP);
    endfunction

endpackage

// File: rtl/ir_period_gen.sv
// Period counter with half-period compare. Inputs carry the run/period values for the coming
// cycle so the LED output can be a true register aligned with the counter.
module ir_period_gen #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             run,
    output logic             led,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] per_q;
    logic             run_q;

    assign tick = run_q && (cnt == per_q - CNT_W'(1));

    // A fresh start or a wrap restarts at 0, so every rising edge sits exactly one period apart
    always_comb begin
        cnt_d = cnt + CNT_W'(1);
        if (!run || !run_q || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            per_q <= '0;
            run_q <= 1'b0;
            led   <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            per_q <= period;
            run_q <= run;
            led   <= run && (cnt_d < (period >> 1));
        end
    end

endmodule

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: square-wave LED drive whose period encodes a decision code,
// with a valid/ready command port, a one-deep pending slot and burst/continuous modes.
module ir_beacon_tx
    import ir_beacon_tx_pkg::*;
#(
    parameter int PER_RB   = DEF_PER_RB,
    parameter int PER_RG   = DEF_PER_RG,
    parameter int PER_BG   = DEF_PER_BG,
    parameter int PER_STOP = DEF_PER_STOP,
    parameter int CNT_W    = 20,
    parameter int BURST_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_code,
    input  logic [BURST_W-1:0] cmd_cycles,
    output logic               cmd_ready,
    output logic               ir_led,
    output logic               busy,
    output logic               period_tick,
    output logic               done
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cur_per, per_d;
    logic [BURST_W-1:0] cur_left, left_d;
    logic               cur_cont, cont_d;
    logic               pend_vld, pend_vld_d;
    logic [2:0]         pend_code, pend_code_d;
    logic [BURST_W-1:0] pend_cyc, pend_cyc_d;
    logic               sel_vld;
    logic [2:0]         sel_code;
    logic [BURST_W-1:0] sel_cyc;
    logic               live;
    logic               done_d;
    logic               tick;
    logic               accept;
    logic               run_d;

    function automatic logic [CNT_W-1:0] per_of(input logic [2:0] code);
        case (code)
            CODE_RB:   per_of = CNT_W'(PER_RB);
            CODE_RG:   per_of = CNT_W'(PER_RG);
            CODE_BG:   per_of = CNT_W'(PER_BG);
            CODE_STOP: per_of = CNT_W'(PER_STOP);
            default:   per_of = '0;
        endcase
    endfunction

    // live holds cmd_ready low through reset and for the release cycle
    assign cmd_ready   = live && ((state == ST_IDLE) || !pend_vld);
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state == ST_RUN);
    assign period_tick = tick;
    assign run_d       = (state_d == ST_RUN);

    always_comb begin
        state_d     = state;
        per_d       = cur_per;
        left_d      = cur_left;
        cont_d      = cur_cont;
        pend_vld_d  = pend_vld;
        pend_code_d = pend_code;
        pend_cyc_d  = pend_cyc;
        done_d      = 1'b0;
        sel_vld     = 1'b0;
        sel_code    = pend_code;
        sel_cyc     = pend_cyc;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sel_vld  = 1'b1;
                    sel_code = cmd_code;
                    sel_cyc  = cmd_cycles;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (pend_vld) begin
                        sel_vld    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else if (accept) begin
                        sel_vld  = 1'b1;
                        sel_code = cmd_code;
                        sel_cyc  = cmd_cycles;
                    end else if (cur_cont) begin
                        state_d = ST_RUN;
                    end else if (cur_left > BURST_W'(1)) begin
                        left_d = cur_left - BURST_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (accept) begin
                    pend_vld_d  = 1'b1;
                    pend_code_d = cmd_code;
                    pend_cyc_d  = cmd_cycles;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // NONE and codes 5..7 end transmission exactly like an exhausted burst
        if (sel_vld) begin
            if (code_legal(sel_code)) begin
                state_d = ST_RUN;
                per_d   = per_of(sel_code);
                left_d  = sel_cyc;
                cont_d  = (sel_cyc == '0);
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_per   <= '0;
            cur_left  <= '0;
            cur_cont  <= 1'b0;
            pend_vld  <= 1'b0;
            pend_code <= '0;
            pend_cyc  <= '0;
            live      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cur_per   <= per_d;
            cur_left  <= left_d;
            cur_cont  <= cont_d;
            pend_vld  <= pend_vld_d;
            pend_code <= pend_code_d;
            pend_cyc  <= pend_cyc_d;
            live      <= 1'b1;
            done      <= done_d;
        end
    end

    ir_period_gen #(
        .CNT_W (CNT_W)
    ) u_gen (
        .clk    (clk),
        .rst    (rst),
        .period (per_d),
        .run    (run_d),
        .led    (ir_led),
        .tick   (tick)
    );

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Directed and randomized bench for ir_beacon_tx: the expected on-air sequence is a list of
// periods from which rising edges, falling edges, ticks and the done pulse follow by arithmetic.
module tb_ir_beacon_tx;

    localparam int P_RB = 40;
    localparam int P_RG = 24;
    localparam int P_BG = 16;
    localparam int P_ST = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_code = 3'd0;
    logic [7:0] cmd_cycles = 8'd0;
    logic       cmd_ready, ir_led, busy, period_tick, done;

    ir_beacon_tx #(
        .PER_RB   (P_RB),
        .PER_RG   (P_RG),
        .PER_BG   (P_BG),
        .PER_STOP (P_ST),
        .CNT_W    (8),
        .BURST_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_cycles  (cmd_cycles),
        .cmd_ready   (cmd_ready),
        .ir_led      (ir_led),
        .busy        (busy),
        .period_tick (period_tick),
        .done        (done)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rise_q[$];
    int   fall_q[$];
    int   tick_q[$];
    int   done_q[$];
    int   exp_per[$];
    logic prev_led = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ir_led === 1'b1 && prev_led === 1'b0) rise_q.push_back(cyc);
        if (ir_led === 1'b0 && prev_led === 1'b1) fall_q.push_back(cyc);
        if (period_tick === 1'b1) tick_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
        prev_led = ir_led;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int per_of(input int code);
        case (code)
            1: return P_RB;
            2: return P_RG;
            3: return P_BG;
            4: return P_ST;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rise_q.delete();
        fall_q.delete();
        tick_q.delete();
        done_q.delete();
        exp_per.delete();
    endtask

    // Called at a falling edge; returns the cycle in which valid&ready was seen
    task automatic send(input int code, input int n, output int acc);
        acc        = -1;
        cmd_code   = 3'(code);
        cmd_cycles = 8'(n);
        cmd_valid  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc >= 0) @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_in_time", 32'(acc >= 0), 1);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 20000 && cyc < c; i++) @(negedge clk);
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 4000; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk("idle_reached", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    // First rising edge at cycle s, then one period per exp_per entry
    task automatic check_air(input int s, input bit ends, input string tag);
        int t;
        t = s;
        chk({tag, "_rises"}, rise_q.size(), exp_per.size());
        chk({tag, "_falls"}, fall_q.size(), exp_per.size());
        chk({tag, "_ticks"}, tick_q.size(), exp_per.size());
        foreach (exp_per[k]) begin
            if (k < rise_q.size()) chk({tag, "_rise_at"}, rise_q[k], t);
            if (k < fall_q.size()) chk({tag, "_fall_at"}, fall_q[k], t + exp_per[k] / 2);
            if (k < tick_q.size()) chk({tag, "_tick_at"}, tick_q[k], t + exp_per[k] - 1);
            t += exp_per[k];
        end
        chk({tag, "_dones"}, done_q.size(), ends ? 1 : 0);
        if (ends && done_q.size() > 0) chk({tag, "_done_at"}, done_q[0], t);
    endtask

    initial begin
        int a, b, c, s, code, n, at;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_led", ir_led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_led", ir_led, 0);
        clear_logs();

        // Burst R_B x3
        send(1, 3, a);
        repeat (3) exp_per.push_back(P_RB);
        idle_wait();
        check_air(a + 1, 1'b1, "burst_rb3");
        clear_logs();

        // Random bursts
        for (int it = 0; it < 6; it++) begin
            code = $urandom_range(1, 4);
            n    = $urandom_range(1, 4);
            send(code, n, a);
            repeat (n) exp_per.push_back(per_of(code));
            idle_wait();
            check_air(a + 1, 1'b1, "rand_burst");
            clear_logs();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Continuous B_G replaced mid-period by STOP, then stopped with NONE
        send(3, 0, a);
        s  = a + 1;
        at = $urandom_range(1, 14);
        wait_cyc(s + at);
        send(4, 0, b);
        chk("bg_stop_acc", b, s + at);
        wait_cyc(s + P_BG + 2 + P_ST);
        send(0, 0, c);
        idle_wait();
        exp_per = '{P_BG, P_ST, P_ST};
        check_air(s, 1'b1, "bg_to_stop");
        clear_logs();

        // Command presented on the last clock of a STOP period goes in directly
        send(4, 0, a);
        s = a + 1;
        wait_cyc(s + 2 * P_ST - 1);
        send(2, 2, b);
        chk("race_acc", b, s + 2 * P_ST - 1);
        idle_wait();
        exp_per = '{P_ST, P_ST, P_RG, P_RG};
        check_air(s, 1'b1, "race");
        clear_logs();

        // Backpressure: second command waits for the pending one to be consumed
        send(1, 0, a);
        s = a + 1;
        wait_cyc(s + 3);
        send(3, 1, b);
        send(2, 1, c);
        chk("bp_second_acc", c, s + P_RB);
        idle_wait();
        exp_per = '{P_RB, P_BG, P_RG};
        check_air(s, 1'b1, "backpressure");
        clear_logs();

        // NONE and illegal code from IDLE
        send(0, 1, a);
        repeat (3) @(negedge clk);
        check_air(a + 1, 1'b1, "none_idle");
        chk("none_idle_busy", busy, 0);
        clear_logs();
        send(7, 2, a);
        repeat (3) @(negedge clk);
        check_air(a + 1, 1'b1, "illegal_idle");
        clear_logs();

        // Illegal code 6 waiting in the pending slot during RUN
        send(2, 0, a);
        s = a + 1;
        wait_cyc(s + $urandom_range(1, P_RG - 2));
        send(6, 0, b);
        idle_wait();
        exp_per = '{P_RG};
        check_air(s, 1'b1, "illegal_pend");
        clear_logs();

        // Asynchronous reset in the middle of a R_G stream
        send(2, 0, a);
        wait_cyc(a + 10);
        rst = 1'b1;
        #1;
        chk("midrst_led", ir_led, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tick", period_tick, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_led", ir_led, 0);
        chk("postrst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
